decoder_nto2n_seq: RTL and testbench

//  Parametrised, registered N-to-2^N one-hot decoder with a valid/ready select

---
 rtl/decoder_nto2n_seq.sv | 145 ++++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready select, programmable hold and auto-scan.
// Optional abort input is enabled by defining DECODER_ABORT_EN.
module decoder_nto2n_seq #(
    parameter int N_SEL  = 3,
    parameter int HOLD_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    input  logic [N_SEL-1:0]      sel,
    input  logic [HOLD_W-1:0]     hold,
    input  logic                  scan_start,
`ifdef DECODER_ABORT_EN
    input  logic                  abort,
`endif
    output logic [(2**N_SEL)-1:0] y,
    output logic                  busy,
    output logic                  done
);

    localparam int OUTS = 2**N_SEL;
    localparam logic [OUTS-1:0] ONE = {{(OUTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t            state, state_n;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic [HOLD_W-1:0] h_len, h_len_n;
    logic [N_SEL-1:0]  idx, idx_n;
    logic [OUTS-1:0]   y_n;
    logic [HOLD_W-1:0] hold_eff;
    logic              last;
    logic              last_line;
    logic              abort_i;

`ifdef DECODER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // h_len stores the effective length (never 0), so H-1 cannot underflow.
    assign hold_eff  = (hold == '0) ? HOLD_W'(1) : hold;
    assign last      = (cnt == (h_len - HOLD_W'(1)));
    assign last_line = (idx == '1);

    assign busy = (state != IDLE);

    always_comb begin
        sel_ready = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: sel_ready = ~scan_start;
            HOLD: begin
                sel_ready = last & ~abort_i;
                done      = last & ~abort_i;
            end
            SCAN: done = last & last_line & ~abort_i;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        h_len_n = h_len;
        idx_n   = idx;
        y_n     = y;
        case (state)
            IDLE: begin
                y_n   = '0;
                cnt_n = '0;
                if (scan_start) begin
                    state_n = SCAN;
                    idx_n   = '0;
                    h_len_n = hold_eff;
                    y_n     = ONE;
                end else if (sel_valid) begin
                    state_n = HOLD;
                    idx_n   = sel;
                    h_len_n = hold_eff;
                    y_n     = ONE << sel;
                end
            end
            HOLD: begin
                if (last) begin
                    cnt_n = '0;
                    // Back-to-back accept reloads in place so y never drops to zero.
                    if (sel_valid) begin
                        idx_n   = sel;
                        h_len_n = hold_eff;
                        y_n     = ONE << sel;
                    end else begin
                        state_n = IDLE;
                        y_n     = '0;
                    end
                end else begin
                    cnt_n = cnt + HOLD_W'(1);
                end
            end
            SCAN: begin
                if (last) begin
                    cnt_n = '0;
                    if (last_line) begin
                        state_n = IDLE;
                        y_n     = '0;
                    end else begin
                        idx_n = idx + N_SEL'(1);
                        y_n   = ONE << (idx + N_SEL'(1));
                    end
                end else begin
                    cnt_n = cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                y_n     = '0;
                cnt_n   = '0;
            end
        endcase
        if (abort_i && state != IDLE) begin
            state_n = IDLE;
            y_n     = '0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            h_len <= '0;
            idx   <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            h_len <= h_len_n;
            idx   <= idx_n;
            y     <= y_n;
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq: directed scenarios plus randomized traffic
// checked against a queue of expected per-cycle outputs.
module tb_decoder_nto2n_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel_valid;
    logic       sel_ready;
    logic [2:0] sel;
    logic [3:0] hold;
    logic       scan_start;
    logic [7:0] y;
    logic       busy;
    logic       done;
`ifdef DECODER_ABORT_EN
    logic       abort;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] y;
        bit         done;
        bit         scan;
    } ent_t;

    // Each entry is what the outputs must show in one future cycle.
    ent_t q[$];

    always #5 clk = ~clk;

    decoder_nto2n_seq #(.N_SEL(3), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel       (sel),
        .hold      (hold),
        .scan_start(scan_start),
`ifdef DECODER_ABORT_EN
        .abort     (abort),
`endif
        .y         (y),
        .busy      (busy),
        .done      (done)
    );

    function automatic int eff(input logic [3:0] h);
        return (h == 4'd0) ? 1 : int'(h);
    endfunction

    function automatic bit ab_now();
`ifdef DECODER_ABORT_EN
        return abort === 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] exp_y();
        return (q.size() != 0) ? q[0].y : 8'h00;
    endfunction

    function automatic logic exp_done();
        return (q.size() != 0) ? (q[0].done && !ab_now()) : 1'b0;
    endfunction

    function automatic logic exp_busy();
        return q.size() != 0;
    endfunction

    function automatic logic exp_ready();
        if (q.size() == 0) return !scan_start;
        return (q.size() == 1) && !q[0].scan && !ab_now();
    endfunction

    task automatic push_hold(input logic [2:0] s, input logic [3:0] h);
        for (int i = 0; i < eff(h); i++)
            q.push_back('{y: 8'h01 << s, done: (i == eff(h) - 1), scan: 1'b0});
    endtask

    task automatic push_scan(input logic [3:0] h);
        for (int l = 0; l < 8; l++)
            for (int i = 0; i < eff(h); i++)
                q.push_back('{y: 8'h01 << l, done: (l == 7 && i == eff(h) - 1), scan: 1'b1});
    endtask

    // Advance the reference by one clock using the inputs currently driven, then clock the DUT.
    task automatic advance();
        bit idle;
        bit acc;
        if (!rst_n) begin
            q.delete();
        end else if (ab_now() && q.size() != 0) begin
            q.delete();
        end else begin
            idle = (q.size() == 0);
            acc  = sel_valid && exp_ready();
            if (!idle) void'(q.pop_front());
            if (idle && scan_start) push_scan(hold);
            else if (acc) push_hold(sel, hold);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] h, input logic st);
        sel_valid  = v;
        sel        = s;
        hold       = h;
        scan_start = st;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        advance();
        advance();
        checks++;
        if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset y=%h busy=%b done=%b expected y=00 busy=0 done=0", y, busy, done);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (sel_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready sel_ready=%b expected 1", sel_ready);
        end
    endtask

    task automatic test_single();
        logic [7:0] lit_y[4] = '{8'h20, 8'h20, 8'h20, 8'h00};
        logic       lit_d[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        drive(1'b1, 3'd5, 4'd3, 1'b0);
        advance();
        drive(1'b0, 3'd1, 4'd9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (y !== lit_y[i] || done !== lit_d[i] || y !== exp_y() || sel_ready !== exp_ready()) begin
                failures++;
                $display("FAIL single cyc=%0d y=%h done=%b rdy=%b expected y=%h done=%b rdy=%b",
                         i, y, done, sel_ready, lit_y[i], lit_d[i], exp_ready());
            end
            advance();
        end
    endtask

    task automatic test_hold_zero();
        logic [7:0] lit_y[2] = '{8'h01, 8'h00};
        logic       lit_b[2] = '{1'b1, 1'b0};
        drive(1'b1, 3'd0, 4'd0, 1'b0);
        advance();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (y !== lit_y[i] || done !== lit_b[i] || busy !== lit_b[i]) begin
                failures++;
                $display("FAIL hold_zero cyc=%0d y=%h done=%b busy=%b expected y=%h done=%b busy=%b",
                         i, y, done, busy, lit_y[i], lit_b[i], lit_b[i]);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] lit_y[4] = '{8'h04, 8'h80, 8'h80, 8'h00};
        logic       lit_d[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        drive(1'b1, 3'd2, 4'd1, 1'b0);
        advance();
        drive(1'b1, 3'd7, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (y !== lit_y[i] || done !== lit_d[i] || sel_ready !== exp_ready() || busy !== exp_busy()) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d y=%h done=%b rdy=%b expected y=%h done=%b rdy=%b",
                         i, y, done, sel_ready, lit_y[i], lit_d[i], exp_ready());
            end
            advance();
            if (i == 0) drive(1'b0, 3'd3, 4'd5, 1'b0);
        end
    endtask

    task automatic test_scan();
        drive(1'b1, 3'd1, 4'd2, 1'b1);
        advance();
        drive(1'b1, 3'd1, 4'd2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (y !== (8'h01 << (i / 2)) || done !== (i == 15) || sel_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL scan cyc=%0d y=%h done=%b rdy=%b busy=%b expected y=%h done=%b rdy=0 busy=1",
                         i, y, done, sel_ready, busy, 8'h01 << (i / 2), (i == 15));
            end
            advance();
        end
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (y !== exp_y() || done !== exp_done() || busy !== exp_busy() || sel_ready !== exp_ready()) begin
                failures++;
                $display("FAIL scan_tail cyc=%0d y=%h/%h done=%b/%b busy=%b/%b rdy=%b/%b (actual/expected)",
                         i, y, exp_y(), done, exp_done(), busy, exp_busy(), sel_ready, exp_ready());
            end
            advance();
        end
    endtask

    task automatic test_hold_max();
        int high = 0;
        drive(1'b1, 3'd3, 4'd15, 1'b0);
        advance();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            if (y === 8'h08) high++;
            checks++;
            if (y !== exp_y() || done !== exp_done() || busy !== exp_busy() || sel_ready !== exp_ready()) begin
                failures++;
                $display("FAIL hold_max cyc=%0d y=%h/%h done=%b/%b busy=%b/%b rdy=%b/%b (actual/expected)",
                         i, y, exp_y(), done, exp_done(), busy, exp_busy(), sel_ready, exp_ready());
            end
            advance();
        end
        checks++;
        if (high != 15) begin
            failures++;
            $display("FAIL hold_max_len high_cycles=%0d expected 15", high);
        end
    endtask

    task automatic test_reset_mid_scan();
        drive(1'b0, 3'd0, 4'd2, 1'b1);
        advance();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) advance();
        checks++;
        if (y !== 8'h08) begin
            failures++;
            $display("FAIL mid_scan_pos y=%h expected 08", y);
        end
        rst_n = 1'b0;
        #1;
        advance();
        checks++;
        if (y !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_scan_reset y=%h done=%b busy=%b expected y=00 done=0 busy=0", y, done, busy);
        end
        rst_n = 1'b1;
        #1;
    endtask

`ifdef DECODER_ABORT_EN
    task automatic test_abort();
        drive(1'b1, 3'd4, 4'd5, 1'b0);
        advance();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        advance();
        abort = 1'b1;
        #1;
        checks++;
        if (y !== 8'h10 || sel_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_cycle y=%h rdy=%b done=%b expected y=10 rdy=0 done=0", y, sel_ready, done);
        end
        advance();
        abort = 1'b0;
        #1;
        checks++;
        if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_after y=%h busy=%b done=%b expected y=00 busy=0 done=0", y, busy, done);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 60), 3'($urandom), 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 5));
            if ($urandom_range(0, 99) < 2) hold = 4'd15;
            rst_n = ($urandom_range(0, 199) != 0);
`ifdef DECODER_ABORT_EN
            abort = ($urandom_range(0, 99) < 3);
`endif
            #1;
            checks++;
            if (y !== exp_y() || done !== exp_done() || busy !== exp_busy() || sel_ready !== exp_ready()) begin
                failures++;
                $display("FAIL random cyc=%0d y=%h/%h done=%b/%b busy=%b/%b rdy=%b/%b (actual/expected)",
                         i, y, exp_y(), done, exp_done(), busy, exp_busy(), sel_ready, exp_ready());
            end
            checks++;
            if ($countones(y) > 1) begin
                failures++;
                $display("FAIL onehot cyc=%0d y=%h expected at most one bit set", i, y);
            end
            advance();
        end
        rst_n = 1'b1;
`ifdef DECODER_ABORT_EN
        abort = 1'b0;
`endif
        #1;
    endtask

    initial begin
`ifdef DECODER_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_single();
        test_hold_zero();
        test_back_to_back();
        test_scan();
        test_hold_max();
        test_reset_mid_scan();
`ifdef DECODER_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
